uart_seq_ctrl: RTL
==================

// Module: uart_seq_ctrl
// PURPOSE
//  Bus-master sequencer for the uart_wrap slave port. Programs the baud divider after reset
//  and on request, drains a TX byte FIFO into the data register, and periodically polls the
//  data register for RX bytes. Lets hardware clients use the UART without CPU involvement.
// PARAMETERS
//  TX_DEPTH     8        TX FIFO entries; power of two, >=2
//  POLL_CYCLES  64       idle cycles between RX polls; >=1
//  DIV_INIT     32'd104  divider value written once after reset release
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous active-low reset
//  uart_sel     out  1   slave select to uart_wrap
//  addr         out  4   4'h8 = divider register, 4'hC = data register
//  uart_wstrb   out  4   byte write strobes; 4'b0000 = read
//  uart_di      out  32  write data
//  uart_do      in   32  read data, valid in the cycle uart_ready=1
//  uart_ready   in   1   transaction-complete strobe from the slave
//  tx_valid     in   1   client TX byte valid
//  tx_data      in   8   client TX byte
//  tx_ready     out  1   FIFO not full (registered)
//  tx_count     out  $clog2(TX_DEPTH)+1  FIFO occupancy
//  rx_valid     out  1   RX byte held
//  rx_data      out  8   RX byte
//  rx_ready     in   1   client consumes RX byte
//  cfg_div      in   32  new divider value
//  cfg_div_wr   in   1   one-cycle request to write cfg_div
//  busy         out  1   FSM not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0 (tx_ready 0, rx_valid 0); FIFO empty, div request cleared, poll counter 0.
//    Reset mid-transaction drops uart_sel asynchronously; no transaction is resumed.
//  - FSM states: BOOT, IDLE, DIV_WR, TX_WR, RX_RD. BOOT lasts one cycle after reset release, then
//    enters DIV_WR with DIV_INIT. tx_ready rises the cycle after BOOT.
//  - IDLE arbitration, fixed priority: pending div > FIFO non-empty > poll due. Transaction issued
//    the cycle after the decision; busy=1 from then.
//  - Bus rule: uart_sel/addr/wstrb/di registered; held stable until uart_ready=1 sampled; uart_sel
//    deasserted the following cycle (min one idle cycle between transactions); no timeout.
//  - DIV_WR: addr 8, wstrb 4'hF, di = latched value. TX_WR: addr C, wstrb 4'b0001, di = {24'b0,byte};
//    FIFO pops on the ready cycle. RX_RD: addr C, wstrb 0.
//  - RX: on ready, uart_do == 32'hFFFF_FFFF means empty (discard); otherwise rx_data <= uart_do[7:0],
//    rx_valid <= 1 next cycle. rx_valid clears on rx_valid&&rx_ready. Poll counter counts IDLE cycles
//    only while rx_valid=0, resets to 0 on each RX_RD; poll due when it reaches POLL_CYCLES-1.
//  - TX push accepted when tx_valid&&tx_ready; full FIFO ignores push. Push+pop same cycle when
//    not full: count unchanged. Pointers wrap modulo TX_DEPTH.
//  - cfg_div_wr in any state latches cfg_div and sets pending; served after the in-flight
//    transaction; a second cfg_div_wr before service overwrites the value (one write results).
// CONFIGURATION
//  UART_SEQ_RX_POLL_EN defined: RX polling, poll counter and rx_* logic present as above.
//  Undefined: RX_RD state and poll counter removed; rx_valid and rx_data tied 0; rx_ready ignored.
// STRUCTURE
//  Package uart_seq_pkg: state enum, ADDR_DIV=4'h8, ADDR_DAT=4'hC, RX_EMPTY=32'hFFFF_FFFF,
//  WSTRB_DIV=4'hF, WSTRB_DAT=4'b0001.
//  Sub-module uart_seq_fifo: synchronous FIFO (TX_DEPTH x 8) with count, full, empty.
// TESTING
//  1 Release reset, DIV_INIT=104 -> first transaction addr 8, wstrb F, di 104; then idle, busy 0.
//  2 Push 0x41,0x42,0x43; stall uart_ready 5 cycles -> outputs stable during stall; bytes written
//    in order, wstrb 0001, one idle cycle between.
//  3 Stall uart_ready, push 9 bytes -> tx_count 8, tx_ready 0, 9th byte dropped, 8 bytes emitted.
//  4 RX poll returns 32'hFFFF_FFFF -> no rx_valid; returns 0x5A -> rx_valid, rx_data 0x5A; with
//    rx_ready 0 no further RX_RD until consumed (needs UART_SEQ_RX_POLL_EN).
//  5 cfg_div_wr=0x1A0 during TX write with FIFO non-empty -> div write next, before next byte.
//  6 reset_n low mid TX write -> uart_sel 0 immediately, tx_count 0; after release BOOT repeats.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// Shared types and constants for the uart_wrap bus-master sequencer.
package uart_seq_pkg;

  typedef enum logic [2:0] {
    StBoot,
    StIdle,
    StDivWr,
    StTxWr,
    StRxRd
  } seq_state_e;

  localparam logic [3:0]  ADDR_DIV  = 4'h8;
  localparam logic [3:0]  ADDR_DAT  = 4'hC;
  localparam logic [31:0] RX_EMPTY  = 32'hFFFF_FFFF;
  localparam logic [3:0]  WSTRB_DIV = 4'hF;
  localparam logic [3:0]  WSTRB_DAT = 4'b0001;
  localparam logic [3:0]  WSTRB_RD  = 4'b0000;

endpackage

// File: rtl/uart_seq_fifo.sv
// Synchronous byte FIFO with occupancy count; pushes when full and pops when empty are ignored.
module uart_seq_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [7:0]             wdata_i,
  input  logic                   pop_i,
  output logic [7:0]             rdata_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic [7:0]      mem_q [Depth];
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage array needs no reset; only entries below count are ever read out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_seq_ctrl.sv
// Bus-master sequencer for the uart_wrap slave port: boot-time divider write, TX FIFO drain,
// on-demand divider writes and (with UART_SEQ_RX_POLL_EN defined) periodic RX polling.
module uart_seq_ctrl
  import uart_seq_pkg::*;
#(
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned POLL_CYCLES = 64,
  parameter logic [31:0] DIV_INIT    = 32'd104
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      uart_sel,
  output logic [3:0]                addr,
  output logic [3:0]                uart_wstrb,
  output logic [31:0]               uart_di,
  input  logic [31:0]               uart_do,
  input  logic                      uart_ready,
  input  logic                      tx_valid,
  input  logic [7:0]                tx_data,
  output logic                      tx_ready,
  output logic [$clog2(TX_DEPTH):0] tx_count,
  output logic                      rx_valid,
  output logic [7:0]                rx_data,
  input  logic                      rx_ready,
  input  logic [31:0]               cfg_div,
  input  logic                      cfg_div_wr,
  output logic                      busy
);

  localparam int unsigned CntW = $clog2(TX_DEPTH) + 1;

  seq_state_e    state_q, state_d;
  logic          sel_q, sel_d;
  logic [3:0]    addr_q, addr_d, wstrb_q, wstrb_d;
  logic [31:0]   di_q, di_d;
  logic          tx_ready_q, tx_ready_d;
  logic          div_pend_q, div_pend_d;
  logic [31:0]   div_val_q, div_val_d;
  logic          div_issue, poll_due, push, pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CntW-1:0] fifo_count, count_nxt;

  assign push = tx_valid && tx_ready_q && !fifo_full;
  assign pop  = (state_q == StTxWr) && uart_ready;

  uart_seq_fifo #(
    .Depth(TX_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .push_i (push),
    .wdata_i(tx_data),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Next state and registered bus outputs; a new transaction is launched only from IDLE, so
  // there is always one deselected cycle between transactions.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wstrb_d   = wstrb_q;
    di_d      = di_q;
    div_issue = 1'b0;
    unique case (state_q)
      StBoot: begin
        state_d = StDivWr;
        sel_d   = 1'b1;
        addr_d  = ADDR_DIV;
        wstrb_d = WSTRB_DIV;
        di_d    = DIV_INIT;
      end
      StIdle: begin
        if (div_pend_q) begin
          state_d   = StDivWr;
          div_issue = 1'b1;
          sel_d     = 1'b1;
          addr_d    = ADDR_DIV;
          wstrb_d   = WSTRB_DIV;
          di_d      = div_val_q;
        end else if (!fifo_empty) begin
          state_d = StTxWr;
          sel_d   = 1'b1;
          addr_d  = ADDR_DAT;
          wstrb_d = WSTRB_DAT;
          di_d    = {24'h0, fifo_rdata};
        end else if (poll_due) begin
          state_d = StRxRd;
          sel_d   = 1'b1;
          addr_d  = ADDR_DAT;
          wstrb_d = WSTRB_RD;
          di_d    = '0;
        end
      end
      default: begin
        if (uart_ready) begin
          state_d = StIdle;
          sel_d   = 1'b0;
          addr_d  = '0;
          wstrb_d = '0;
          di_d    = '0;
        end
      end
    endcase
  end

  // Divider request latch (a newer request overwrites an unserved one) and FIFO-space flag.
  always_comb begin
    div_pend_d = cfg_div_wr || (div_pend_q && !div_issue);
    div_val_d  = cfg_div_wr ? cfg_div : div_val_q;
    count_nxt  = fifo_count + CntW'(push) - CntW'(pop);
    tx_ready_d = (count_nxt != CntW'(TX_DEPTH));
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StBoot;
      sel_q      <= 1'b0;
      addr_q     <= '0;
      wstrb_q    <= '0;
      di_q       <= '0;
      tx_ready_q <= 1'b0;
      div_pend_q <= 1'b0;
      div_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wstrb_q    <= wstrb_d;
      di_q       <= di_d;
      tx_ready_q <= tx_ready_d;
      div_pend_q <= div_pend_d;
      div_val_q  <= div_val_d;
    end
  end

`ifdef UART_SEQ_RX_POLL_EN
  localparam int unsigned PollW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  logic [PollW-1:0] poll_q, poll_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;

  assign poll_due = !rx_valid_q && (poll_q == PollW'(POLL_CYCLES - 1));

  // Poll counter saturates at the due value and freezes while an RX byte is held.
  always_comb begin
    poll_d     = poll_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (state_q == StIdle) begin
      if (state_d == StRxRd) begin
        poll_d = '0;
      end else if (!rx_valid_q && (poll_q != PollW'(POLL_CYCLES - 1))) begin
        poll_d = poll_q + 1'b1;
      end
    end
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if ((state_q == StRxRd) && uart_ready && (uart_do != RX_EMPTY)) begin
      rx_valid_d = 1'b1;
      rx_data_d  = uart_do[7:0];
    end
  end

  // RX holding register and poll counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      poll_q     <= poll_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
`else
  logic unused_rx;

  assign poll_due  = 1'b0;
  assign unused_rx = ^{rx_ready, uart_do};
  assign rx_valid  = 1'b0;
  assign rx_data   = '0;
`endif

  assign uart_sel   = sel_q;
  assign addr       = addr_q;
  assign uart_wstrb = wstrb_q;
  assign uart_di    = di_q;
  assign tx_ready   = tx_ready_q;
  assign tx_count   = fifo_count;
  // BOOT is treated as not busy so every output reads 0 straight out of reset.
  assign busy       = (state_q != StIdle) && (state_q != StBoot);

endmodule
